// File: rtl/sparse_stream_pkg.sv
// Shared definitions for the sparse PE result stream: word layout, token
// classification helpers and the zero-filter state encoding.
package sparse_stream_pkg;

    localparam int unsigned STREAM_W = 17;
    localparam int unsigned CTRL_BIT = 16;
    localparam logic [STREAM_W-1:0] DONE_TOKEN = 17'h10100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } zf_state_t;

    function automatic logic is_ctrl(input logic [STREAM_W-1:0] w);
        return w[CTRL_BIT];
    endfunction

    function automatic logic is_done(input logic [STREAM_W-1:0] w);
        return w == DONE_TOKEN;
    endfunction

    // A zero value is a data word (flag clear) whose payload is all zeros.
    function automatic logic is_zero_val(input logic [STREAM_W-1:0] w);
        return !w[CTRL_BIT] && (w[CTRL_BIT-1:0] == '0);
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry shift FIFO; entry 0 is always the head and vacated entries are
// cleared so the head reads zero when the FIFO is empty.
module stream_fifo2 #(
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        pop_ok  = pop && (cnt_q != 2'd0);
        push_ok = push && ((cnt_q != 2'd2) || pop_ok);
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q;
        if (clear) begin
            e0_d  = '0;
            e1_d  = '0;
            cnt_d = 2'd0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (push_ok) begin
                        e0_d  = din;
                        cnt_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push_ok && pop_ok) begin
                        e0_d = din;
                    end else if (push_ok) begin
                        e1_d  = din;
                        cnt_d = 2'd2;
                    end else if (pop_ok) begin
                        e0_d  = '0;
                        cnt_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop_ok) begin
                        e0_d = e1_q;
                        if (push_ok) begin
                            e1_d = din;
                        end else begin
                            e1_d  = '0;
                            cnt_d = 2'd1;
                        end
                    end
                end
                default: begin
                    e0_d  = '0;
                    e1_d  = '0;
                    cnt_d = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = e0_q;
    assign count = cnt_q;

endmodule

// File: rtl/pe_out_zero_filter.sv
// Filters explicit zero values out of the PE result stream, passes tokens
// untouched, counts dropped/forwarded values and freezes after the done token.
module pe_out_zero_filter
    import sparse_stream_pkg::*;
#(
    parameter int unsigned DATA_W = 17,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              tile_en,
    input  logic              drop_zero_en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  dropped_count,
    output logic [CNT_W-1:0]  passed_count,
    output logic              done
);

    zf_state_t         state_q, state_d;
    logic [CNT_W-1:0]  dropped_q, dropped_d;
    logic [CNT_W-1:0]  passed_q, passed_d;
    logic [DATA_W-1:0] fifo_head;
    logic [1:0]        fifo_count;
    logic [STREAM_W-1:0] in_w;
    logic [STREAM_W-1:0] head_w;
    logic              accepting;
    logic              in_fire;
    logic              drop_hit;
    logic              push;
    logic              pop;
    logic              fifo_clear;

    assign in_w      = STREAM_W'(in_data);
    assign head_w    = STREAM_W'(fifo_head);
    assign accepting = (state_q == IDLE) || (state_q == STREAM);

    assign in_ready  = tile_en && clk_en && accepting && (fifo_count < 2'd2);
    assign out_valid = tile_en && (fifo_count != 2'd0);
    assign out_data  = fifo_head;

    assign in_fire    = in_valid && in_ready;
    assign drop_hit   = drop_zero_en && is_zero_val(in_w);
    assign fifo_clear = flush && clk_en;
    assign push       = in_fire && !drop_hit && !flush;
    assign pop        = out_valid && out_ready && clk_en && !flush;

    stream_fifo2 #(
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (fifo_clear),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .head  (fifo_head),
        .count (fifo_count)
    );

    // State and saturating counters; flush wins over any transfer.
    always_comb begin
        state_d   = state_q;
        dropped_d = dropped_q;
        passed_d  = passed_q;
        if (flush) begin
            state_d   = IDLE;
            dropped_d = '0;
            passed_d  = '0;
        end else begin
            case (state_q)
                IDLE, STREAM: begin
                    if (in_fire) begin
                        state_d = is_done(in_w) ? DRAIN : STREAM;
                    end
                end
                DRAIN: begin
                    if (pop && is_done(head_w)) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
            if (in_fire && drop_hit && (dropped_q != '1)) begin
                dropped_d = dropped_q + CNT_W'(1);
            end
            if (push && !is_ctrl(in_w) && (passed_q != '1)) begin
                passed_d = passed_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dropped_q <= '0;
            passed_q  <= '0;
        end else if (clk_en) begin
            state_q   <= state_d;
            dropped_q <= dropped_d;
            passed_q  <= passed_d;
        end
    end

    assign dropped_count = dropped_q;
    assign passed_count  = passed_q;
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_pe_out_zero_filter.sv
// Self-checking bench for pe_out_zero_filter: a queue-based reference model
// is checked every cycle, plus a vector table and directed sequences.
module tb_pe_out_zero_filter;

    localparam logic [16:0] DONE_W = 17'h10100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        flush;
    logic        tile_en;
    logic        drop_zero_en;
    logic [16:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dropped_count;
    logic [15:0] passed_count;
    logic        done;

    pe_out_zero_filter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_en        (clk_en),
        .flush         (flush),
        .tile_en       (tile_en),
        .drop_zero_en  (drop_zero_en),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .dropped_count (dropped_count),
        .passed_count  (passed_count),
        .done          (done)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: word queue plus a few flags.
    logic [16:0] mq[$];
    logic [16:0] got_q[$];
    bit          m_acc_done;
    bit          m_done;
    int          m_drop;
    int          m_pass;
    bit          last_acc;

    typedef struct {
        logic [16:0] w;
        bit          drop;
        bit          ov;
        logic [16:0] od;
        bit          rdy;
        logic [15:0] dc;
        logic [15:0] pc;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_acc_done = 1'b0;
        m_done     = 1'b0;
        m_drop     = 0;
        m_pass     = 0;
    endtask

    task automatic tick(input bit do_chk);
        bit          e_rdy;
        bit          e_ov;
        bit          pop;
        bit          acc;
        logic [16:0] e_od;
        logic [16:0] w;
        #1;
        e_rdy = tile_en && clk_en && !m_acc_done && (mq.size() < 2);
        e_ov  = tile_en && (mq.size() > 0);
        e_od  = (mq.size() > 0) ? mq[0] : 17'h0;
        if (do_chk) begin
            check("in_ready", 32'(in_ready), 32'(e_rdy));
            check("out_valid", 32'(out_valid), 32'(e_ov));
            check("out_data", 32'(out_data), 32'(e_od));
            check("done", 32'(done), 32'(m_done));
            check("dropped_count", 32'(dropped_count), 32'(m_drop));
            check("passed_count", 32'(passed_count), 32'(m_pass));
        end
        pop = e_ov && out_ready;
        acc = in_valid && e_rdy;
        if (out_valid && out_ready && clk_en && !flush) got_q.push_back(out_data);
        last_acc = acc && clk_en && !flush;
        @(posedge clk);
        if (clk_en && rst_n) begin
            if (flush) begin
                model_reset();
            end else begin
                if (pop) begin
                    w = mq.pop_front();
                    if (w == DONE_W) m_done = 1'b1;
                end
                if (acc) begin
                    if (drop_zero_en && in_data == 17'h0) begin
                        if (m_drop < 65535) m_drop++;
                    end else begin
                        mq.push_back(in_data);
                        if (!in_data[16] && m_pass < 65535) m_pass++;
                    end
                    if (in_data == DONE_W) m_acc_done = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic send(input logic [16:0] w);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 30 && !ok; k++) begin
            tick(1);
            ok = last_acc;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL send_timeout: word %0h not accepted within 30 cycles", w);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && mq.size() > 0; k++) tick(1);
        n_cmp++;
        if (mq.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d words still queued", mq.size());
        end
    endtask

    task automatic flush_cycle();
        clk_en  = 1'b1;
        tile_en = 1'b1;
        flush   = 1'b1;
        tick(1);
        flush   = 1'b0;
    endtask

    task automatic check_list(input string name, input logic [16:0] exp[$]);
        check({name, "_len"}, 32'(got_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got_q.size()) check({name, "_word"}, 32'(got_q[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] seq[6];
        logic [16:0] exp_q[$];
        logic [16:0] acc_q[$];
        logic [16:0] w;
        int          r;

        vt[0] = '{17'h00000, 1'b1, 1'b0, 17'h00000, 1'b1, 16'd1, 16'd0};
        vt[1] = '{17'h00000, 1'b0, 1'b1, 17'h00000, 1'b1, 16'd0, 16'd1};
        vt[2] = '{17'h00005, 1'b1, 1'b1, 17'h00005, 1'b1, 16'd0, 16'd1};
        vt[3] = '{17'h10000, 1'b1, 1'b1, 17'h10000, 1'b1, 16'd0, 16'd0};
        vt[4] = '{17'h10100, 1'b1, 1'b1, 17'h10100, 1'b0, 16'd0, 16'd0};
        vt[5] = '{17'h1FFFF, 1'b1, 1'b1, 17'h1FFFF, 1'b1, 16'd0, 16'd0};
        vt[6] = '{17'h10101, 1'b1, 1'b1, 17'h10101, 1'b1, 16'd0, 16'd0};
        vt[7] = '{17'h0FFFF, 1'b1, 1'b1, 17'h0FFFF, 1'b1, 16'd0, 16'd1};
        seq = '{17'h00005, 17'h00000, 17'h00000, 17'h00007, 17'h10000, 17'h10100};

        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1;
        drop_zero_en = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dropped", 32'(dropped_count), 32'd0);
        check("rst_passed", 32'(passed_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Single-word vector table.
        for (int i = 0; i < 8; i++) begin
            flush_cycle();
            drop_zero_en = vt[i].drop;
            out_ready    = 1'b0;
            in_valid     = 1'b1;
            in_data      = vt[i].w;
            tick(1);
            in_valid = 1'b0;
            #1;
            check("vec_out_valid", 32'(out_valid), 32'(vt[i].ov));
            check("vec_out_data", 32'(out_data), 32'(vt[i].od));
            check("vec_in_ready", 32'(in_ready), 32'(vt[i].rdy));
            check("vec_dropped", 32'(dropped_count), 32'(vt[i].dc));
            check("vec_passed", 32'(passed_count), 32'(vt[i].pc));
        end

        // Zero dropping enabled.
        flush_cycle();
        drop_zero_en = 1'b1; out_ready = 1'b1; got_q.delete();
        foreach (seq[i]) send(seq[i]);
        drain();
        tick(1);
        exp_q = '{17'h00005, 17'h00007, 17'h10000, 17'h10100};
        check_list("drop_on", exp_q);
        check("drop_on_dropped", 32'(dropped_count), 32'd2);
        check("drop_on_passed", 32'(passed_count), 32'd2);
        check("drop_on_done", 32'(done), 32'd1);

        // Zero dropping disabled.
        flush_cycle();
        drop_zero_en = 1'b0; out_ready = 1'b1; got_q.delete();
        foreach (seq[i]) send(seq[i]);
        drain();
        tick(1);
        exp_q = '{17'h00005, 17'h00000, 17'h00000, 17'h00007, 17'h10000, 17'h10100};
        check_list("drop_off", exp_q);
        check("drop_off_dropped", 32'(dropped_count), 32'd0);
        check("drop_off_passed", 32'(passed_count), 32'd4);

        // Backpressure: queue holds exactly two words.
        flush_cycle();
        drop_zero_en = 1'b0; out_ready = 1'b0; got_q.delete(); acc_q.delete();
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = 17'(k + 1);
            w = in_data;
            tick(1);
            if (last_acc) acc_q.push_back(w);
        end
        in_valid = 1'b0;
        #1;
        check("bp_accepted", 32'(acc_q.size()), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        drain();
        check_list("bp_order", acc_q);

        // Input after the done token is refused; flush restarts.
        flush_cycle();
        drop_zero_en = 1'b1; out_ready = 1'b1;
        send(17'h00003);
        send(DONE_W);
        in_valid = 1'b1; in_data = 17'h00009;
        repeat (6) tick(1);
        in_valid = 1'b0;
        check("post_done_in_ready", 32'(in_ready), 32'd0);
        check("post_done_done", 32'(done), 32'd1);
        check("post_done_passed", 32'(passed_count), 32'd1);
        flush_cycle();
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_passed", 32'(passed_count), 32'd0);
        check("flush_done", 32'(done), 32'd0);

        // Asynchronous reset with two words queued.
        out_ready = 1'b0;
        send(17'h0000B);
        send(17'h0000C);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_passed", 32'(passed_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);

        // tile_en and clk_en hold everything.
        drop_zero_en = 1'b1; out_ready = 1'b1;
        send(17'h00021);
        out_ready = 1'b0;
        send(17'h00022);
        out_ready = 1'b1; tile_en = 1'b0; in_valid = 1'b1; in_data = 17'h00000;
        repeat (4) tick(1);
        tile_en = 1'b1; clk_en = 1'b0;
        repeat (4) tick(1);
        check("hold_passed", 32'(passed_count), 32'd2);
        check("hold_dropped", 32'(dropped_count), 32'd0);
        clk_en = 1'b1; in_valid = 1'b0;
        drain();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            tile_en   = ($urandom % 10) != 0;
            clk_en    = ($urandom % 10) != 0;
            flush     = ($urandom % 150) == 0;
            if (($urandom % 50) == 0) drop_zero_en = $urandom % 2;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            r = $urandom % 16;
            if (r < 6) begin
                w = 17'h0;
            end else if (r == 6) begin
                w = {1'b1, 16'($urandom)};
                if (w == DONE_W) w = 17'h10000;
            end else if (r == 7 && ($urandom % 6) == 0) begin
                w = DONE_W;
            end else begin
                w = {1'b0, 16'($urandom)};
            end
            in_data = w;
            tick(1);
        end
        flush = 1'b0; tile_en = 1'b1; clk_en = 1'b1;

        // Dropped counter saturation.
        flush_cycle();
        drop_zero_en = 1'b1; in_data = 17'h0; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 70000; k++) tick(0);
        in_valid = 1'b0;
        tick(1);
        check("sat_dropped", 32'(dropped_count), 32'h0000FFFF);
        check("sat_passed", 32'(passed_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
